// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed MULT (radix-2 Booth) / DIV (restoring) sequencer
// producing HI/LO results and write strobes for the multicycle processor.
module muldiv_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              hi_w,
    output logic              lo_w
);

    // Booth register: {guard+acc (DATA_W+1), multiplier (DATA_W), q_-1}.
    // The guard bit keeps acc - mcand exact when mcand is the most negative value.
    localparam int unsigned PROD_W = 2*DATA_W + 2;
    localparam int unsigned ACC_W  = DATA_W + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MULT_RUN = 3'd1,
        S_DIV_RUN  = 3'd2,
        S_DIV_FIX  = 3'd3,
        S_FINISH   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [PROD_W-1:0]   prod_q;
    logic [DATA_W-1:0]   mcand_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvsr_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic                op_q;
    logic                err_q;

    logic                accept_c;
    logic                last_step_c;
    logic [DATA_W-1:0]   a_mag_c;
    logic [DATA_W-1:0]   b_mag_c;
    logic [ACC_W-1:0]    booth_acc_c;
    logic [ACC_W-1:0]    booth_mext_c;
    logic [ACC_W-1:0]    booth_sum_c;
    logic [PROD_W-1:0]   booth_step_c;
    logic [DATA_W:0]     div_shift_c;
    logic                div_ge_c;
    logic [DATA_W-1:0]   div_diff_c;

    logic                busy_d;
    logic                done_d;
    logic                div_zero_d;
    logic                hi_w_d;
    logic                lo_w_d;
    logic [DATA_W-1:0]   hi_d;
    logic [DATA_W-1:0]   lo_d;

    // Request acceptance and iteration-end detection
    assign accept_c    = (state_q == S_IDLE) && start && !busy && !done;
    assign last_step_c = (cnt_q == CNT_W'(DATA_W - 1));
    assign a_mag_c     = a[DATA_W-1] ? -a : a;
    assign b_mag_c     = b[DATA_W-1] ? -b : b;

    // One Booth step: add/subtract on the bit pair, then arithmetic shift right
    always_comb begin
        booth_acc_c  = prod_q[PROD_W-1 -: ACC_W];
        booth_mext_c = {mcand_q[DATA_W-1], mcand_q};
        booth_sum_c  = booth_acc_c;
        case (prod_q[1:0])
            2'b01:   booth_sum_c = booth_acc_c + booth_mext_c;
            2'b10:   booth_sum_c = booth_acc_c - booth_mext_c;
            default: booth_sum_c = booth_acc_c;
        endcase
        booth_step_c = {booth_sum_c[ACC_W-1], booth_sum_c, prod_q[DATA_W:1]};
    end

    // One restoring-division step on magnitudes
    always_comb begin
        div_shift_c = {rem_q, quo_q[DATA_W-1]};
        div_ge_c    = (div_shift_c >= {1'b0, dvsr_q});
        div_diff_c  = div_shift_c[DATA_W-1:0] - dvsr_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (!op)           state_d = S_MULT_RUN;
                    else if (b != '0)  state_d = S_DIV_RUN;
                    else               state_d = S_FINISH;
                end
            end
            S_MULT_RUN: if (last_step_c) state_d = S_FINISH;
            S_DIV_RUN:  if (last_step_c) state_d = S_DIV_FIX;
            S_DIV_FIX:  state_d = S_FINISH;
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        busy_d     = busy;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        hi_w_d     = 1'b0;
        lo_w_d     = 1'b0;
        hi_d       = hi;
        lo_d       = lo;
        case (state_q)
            S_IDLE: begin
                if (accept_c) busy_d = 1'b1;
            end
            S_FINISH: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (err_q) begin
                    div_zero_d = 1'b1;
                end else begin
                    hi_w_d = 1'b1;
                    lo_w_d = 1'b1;
                    if (op_q) begin
                        hi_d = rem_q;
                        lo_d = quo_q;
                    end else begin
                        hi_d = prod_q[2*DATA_W:DATA_W+1];
                        lo_d = prod_q[DATA_W:1];
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_w     <= 1'b0;
            lo_w     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            div_zero <= div_zero_d;
            hi_w     <= hi_w_d;
            lo_w     <= lo_w_d;
            hi       <= hi_d;
            lo       <= lo_d;
        end
    end

    // Operand capture, iteration counter and shift/accumulate datapath
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        cnt_q     <= '0;
                        mcand_q   <= a;
                        prod_q    <= {{ACC_W{1'b0}}, b, 1'b0};
                        rem_q     <= '0;
                        quo_q     <= a_mag_c;
                        dvsr_q    <= b_mag_c;
                        neg_quo_q <= a[DATA_W-1] ^ b[DATA_W-1];
                        neg_rem_q <= a[DATA_W-1];
                        op_q      <= op;
                        err_q     <= op && (b == '0);
                    end
                end
                S_MULT_RUN: begin
                    prod_q <= booth_step_c;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                S_DIV_RUN: begin
                    if (div_ge_c) begin
                        rem_q <= div_diff_c;
                        quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_q <= div_shift_c[DATA_W-1:0];
                        quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_DIV_FIX: begin
                    if (neg_quo_q) quo_q <= -quo_q;
                    if (neg_rem_q) rem_q <= -rem_q;
                end
                default: ;
            endcase
        end
    end

endmodule
